// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's data-memory port and the memory-side responder.
// The master drives requests and consumes responses; the slave does the opposite.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: word-addressed RAM behind a fixed wait-state latency,
// with range/alignment error reporting and word 0's low half exported for observation.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned LATENCY    = 2
) (
    input  logic               CLK,
    input  logic               RST,
    dmem_responder_if.slave    bus,
    output logic [15:0]        test_value
);

    localparam int Words = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

    stateT                 state;
    logic [3:0]            waitCnt;
    logic                  latWe;
    logic [31:0]           latAddr;
    logic [31:0]           latWdata;
    logic                  reqReady;
    logic                  rspValid;
    logic                  rspErr;
    logic [31:0]           rspRdata;
    logic [31:0]           mem [Words];

    logic                  accErr;
    logic [DEPTH_LOG2-1:0] accIdx;

    // Any bit above the RAM's byte range makes the access an error; nothing aliases.
    assign accErr = (latAddr[1:0] != 2'b00) || ((latAddr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign accIdx = latAddr[DEPTH_LOG2+1:2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= StIdle;
            waitCnt  <= 4'd0;
            latWe    <= 1'b0;
            latAddr  <= 32'd0;
            latWdata <= 32'd0;
            reqReady <= 1'b1;
            rspValid <= 1'b0;
            rspRdata <= 32'd0;
            rspErr   <= 1'b0;
            for (int i = 0; i < Words; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        latWe    <= bus.req_we;
                        latAddr  <= bus.req_addr;
                        latWdata <= bus.req_wdata;
                        waitCnt  <= 4'(LATENCY - 1);
                        reqReady <= 1'b0;
                        state    <= StWait;
                    end
                end
                StWait: begin
                    if (waitCnt == 4'd0) begin
                        state    <= StResp;
                        rspValid <= 1'b1;
                        if (accErr) begin
                            rspErr   <= 1'b1;
                            rspRdata <= 32'd0;
                        end else if (latWe) begin
                            mem[accIdx] <= latWdata;
                            rspErr      <= 1'b0;
                            rspRdata    <= 32'd0;
                        end else begin
                            rspErr   <= 1'b0;
                            rspRdata <= mem[accIdx];
                        end
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                StResp: begin
                    // Return to IDLE first; a pending request is taken on the next edge.
                    if (bus.rsp_ready) begin
                        state    <= StIdle;
                        rspValid <= 1'b0;
                        rspRdata <= 32'd0;
                        rspErr   <= 1'b0;
                        reqReady <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = reqReady;
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_rdata = rspRdata;
    assign bus.rsp_err   = rspErr;
    assign test_value    = mem[0][15:0];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main flows and a
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        CLK;
    logic        RST;
    logic [15:0] testValueA;
    logic [15:0] testValueB;

    dmem_responder_if busA ();
    dmem_responder_if busB ();

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) dutA (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (busA),
        .test_value (testValueA)
    );

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(1)) dutB (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (busB),
        .test_value (testValueB)
    );

    int nChecks = 0;
    int nPass   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got === want) nPass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full transaction on busA from IDLE with rsp_ready high; lat counts edges after accept.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic readyAfter);
        busA.req_valid = 1'b1;
        busA.req_we    = we;
        busA.req_addr  = addr;
        busA.req_wdata = wdata;
        busA.rsp_ready = 1'b1;
        tick();
        busA.req_valid = 1'b0;
        readyAfter = busA.req_ready;
        lat = 0;
        while (!busA.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rdata = busA.rsp_rdata;
        err   = busA.rsp_err;
        tick();
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rdy;
    logic        stable;
    int          rspCount;

    initial begin
        RST = 1'b1;
        busA.req_valid = 1'b0; busA.req_we = 1'b0; busA.req_addr = 32'd0;
        busA.req_wdata = 32'd0; busA.rsp_ready = 1'b0;
        busB.req_valid = 1'b0; busB.req_we = 1'b0; busB.req_addr = 32'd0;
        busB.req_wdata = 32'd0; busB.rsp_ready = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        tick();

        check("rst_req_ready", busA.req_ready, 1);
        check("rst_rsp_valid", busA.rsp_valid, 0);
        check("rst_rsp_rdata", busA.rsp_rdata, 0);
        check("rst_rsp_err", busA.rsp_err, 0);
        check("rst_test_value", testValueA, 0);

        xact(1'b1, 32'h0, 32'hDEADBEEF, rd, er, lat, rdy);
        check("st0_ready_drop", rdy, 0);
        check("st0_latency", lat, 2);
        check("st0_err", er, 0);
        check("st0_rdata", rd, 0);
        check("st0_test_value", testValueA, 32'hBEEF);

        xact(1'b1, 32'h10, 32'h12345678, rd, er, lat, rdy);
        check("st10_err", er, 0);
        xact(1'b0, 32'h10, 32'h0, rd, er, lat, rdy);
        check("ld10_rdata", rd, 32'h12345678);
        check("ld10_err", er, 0);
        xact(1'b0, 32'h14, 32'h0, rd, er, lat, rdy);
        check("ld14_rdata", rd, 0);

        xact(1'b0, 32'h6, 32'h0, rd, er, lat, rdy);
        check("ld6_err", er, 1);
        check("ld6_rdata", rd, 0);
        xact(1'b1, 32'h100, 32'hCAFEF00D, rd, er, lat, rdy);
        check("st100_err", er, 1);
        check("st100_rdata", rd, 0);
        xact(1'b0, 32'h0, 32'h0, rd, er, lat, rdy);
        check("ld0_unchanged", rd, 32'hDEADBEEF);
        check("tv_unchanged", testValueA, 32'hBEEF);

        // Back-pressure with a second request held on the request channel throughout.
        busA.req_we = 1'b0; busA.req_addr = 32'h10; busA.req_valid = 1'b1; busA.rsp_ready = 1'b0;
        tick();
        busA.req_addr = 32'h0;
        tick();
        tick();
        check("bp_valid", busA.rsp_valid, 1);
        check("bp_rdata", busA.rsp_rdata, 32'h12345678);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busA.rsp_valid !== 1'b1 || busA.rsp_rdata !== 32'h12345678 || busA.req_ready !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        busA.rsp_ready = 1'b1;
        tick();
        check("bp_idle_ready", busA.req_ready, 1);
        check("bp_idle_valid", busA.rsp_valid, 0);
        tick();
        busA.req_valid = 1'b0;
        check("held_accepted", busA.req_ready, 0);
        tick();
        tick();
        check("held_valid", busA.rsp_valid, 1);
        check("held_rdata", busA.rsp_rdata, 32'hDEADBEEF);
        rspCount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busA.rsp_valid) rspCount++;
        end
        check("held_once", rspCount, 0);

        // Reset pulse while a store is still waiting for its access edge.
        busA.req_we = 1'b1; busA.req_addr = 32'h20; busA.req_wdata = 32'h55AA55AA;
        busA.req_valid = 1'b1;
        tick();
        busA.req_valid = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        check("midrst_valid", busA.rsp_valid, 0);
        check("midrst_ready", busA.req_ready, 1);
        check("midrst_test_value", testValueA, 0);
        #2;
        RST = 1'b0;
        tick();
        xact(1'b0, 32'h20, 32'h0, rd, er, lat, rdy);
        check("midrst_ld20", rd, 0);
        xact(1'b0, 32'h0, 32'h0, rd, er, lat, rdy);
        check("midrst_ld0", rd, 0);

        // LATENCY=1 instance, request valid and response ready held high.
        busB.req_we = 1'b0; busB.req_addr = 32'h8; busB.rsp_ready = 1'b1; busB.req_valid = 1'b1;
        check("b2b_start_ready", busB.req_ready, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("b2b_valid", busB.rsp_valid, 32'((i % 3) == 1));
            check("b2b_ready", busB.req_ready, 32'((i % 3) == 2));
            if ((i % 3) == 1) check("b2b_rdata", busB.rsp_rdata, 0);
        end
        busB.req_valid = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts one load/store request at a time over a valid/ready request channel.
- After a fixed, parameterised wait-state latency it returns a response over a valid/ready response channel.
- Holds a word-addressed RAM, flags bad addresses, and exports the low half of word 0 as `test_value` for board/bench observation.

Parameters:
- DEPTH_LOG2, 6, log2 of the number of 32-bit words (64 words).
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester consumes the response this cycle.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request addressed a misaligned or out-of-range location.
- test_value  output  16  mem[0][15:0].

Behaviour:
- Reset (asynchronous, RST=1):
  - FSM goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - All RAM words are cleared to 0, so test_value=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is accepted: latch we/addr/wdata, load counter with LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge.
  - On the edge where counter==0, the access is performed and the FSM goes to RESP.
- Access, performed at the WAIT→RESP edge:
  - err = (addr[1:0]!=0) or (addr[31:DEPTH_LOG2+2]!=0).
  - err=1: no RAM change, rdata=0, rsp_err=1.
  - Store, no error: mem[addr[DEPTH_LOG2+1:2]] <= wdata, rsp_rdata=0, rsp_err=0.
  - Load, no error: rsp_rdata = mem[index] as it stood before this edge, rsp_err=0.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0 (back-pressure has no length limit).
  - On an edge with rsp_ready=1: go to IDLE, rsp_valid=0, rsp_rdata and rsp_err return to 0.
- Latency: request accepted at edge k means rsp_valid is high after edge k+LATENCY. Minimum request-to-request spacing is LATENCY+2 cycles.
- Ordering:
  - A store is committed before its response is visible.
  - A load issued after a store's response was consumed returns the stored value.
- Request-channel rule: req_* inputs are ignored outside IDLE, and no queueing is done. A request held during WAIT/RESP is accepted on the first IDLE edge.
- Simultaneous events: rsp_ready during the same cycle that req_valid is asserted does not overlap transactions. IDLE is entered first, and the new request is accepted on the following edge.
- Reset mid-operation:
  - Any in-flight request is dropped.
  - A store not yet at its access edge does not write.
  - The RAM is cleared regardless.
- test_value: combinational from mem[0][15:0]. It updates the cycle after a store to byte address 0.
- Addresses wrap nowhere. Any address outside 0..(4<<DEPTH_LOG2)-4 is an error, never aliased.

Test Plan:
- Reset then store 0xDEADBEEF to addr 0x0 with rsp_ready=1, LATENCY=2:
  - req_ready drops after the accept edge.
  - rsp_valid is high after accept+2 edges, with rsp_err=0 and rsp_rdata=0.
  - test_value=0xBEEF.
- Store 0x12345678 to addr 0x10, then load addr 0x10:
  - Load response rsp_rdata=0x12345678, rsp_err=0.
  - Load from addr 0x14 (never written) returns 0.
- Misaligned load at 0x6, and store at 0x100 (out of range for 64 words):
  - Both give rsp_err=1 and rsp_rdata=0.
  - A following load of 0x0 (previously written) shows RAM unchanged.
- Back-pressure: load completes with rsp_ready=0 for 5 cycles:
  - rsp_valid and rsp_rdata stay stable.
  - A req_valid held during that time is not accepted until IDLE, then accepted exactly once.
- Store accepted, then RST pulsed during WAIT:
  - rsp_valid=0 and req_ready=1 immediately.
  - A later load of the target address returns 0.
- LATENCY=1 build, back-to-back requests with rsp_ready tied high:
  - Accept → rsp_valid after 1 edge, one response per 3 cycles.
